// File: rtl/clk_en_gen_pkg.sv
// clk_en_gen_pkg: shared types and constants for the clk_en_gen_n NCO
// clock-enable generator.
//   state_t        - config/lock FSM states
//   MAX_NUM_CLK    - upper bound on channel count
//   MIN/MAX_ACC_W  - supported accumulator width range
//   settle_cnt_w() - width of the settle counter for a given SETTLE value
// Optional feature macro used by this slice: CLK_EN_GEN_PHASE_EN.
package clk_en_gen_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_LOCKED = 2'd1,
        ST_LOAD   = 2'd2
    } state_t;

    localparam int unsigned MAX_NUM_CLK = 16;
    localparam int unsigned MIN_ACC_W   = 8;
    localparam int unsigned MAX_ACC_W   = 48;

    // Counter must hold values 0..SETTLE; never narrower than one bit.
    function automatic int unsigned settle_cnt_w(input int unsigned settle);
        int unsigned w;
        w = $clog2(settle + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_en_gen_n_nco.sv
// clk_en_nco: one numerically controlled oscillator channel.
//   clk, rst_n   - reference clock, async active-low reset
//   load         - one-cycle strobe: take load_inc, preload accumulator
//   load_inc     - new frequency word
//   load_phase   - accumulator preload (used only with CLK_EN_GEN_PHASE_EN)
//   strobe       - registered accumulator carry (one-cycle clock enable)
//   msb          - registered accumulator MSB (square wave)
// Macro CLK_EN_GEN_PHASE_EN: when defined the accumulator is preloaded with
// load_phase on load, otherwise it restarts from zero.
module clk_en_nco #(
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic [ACC_W-1:0] load_phase,
    output logic             strobe,
    output logic             msb
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] preload;

`ifdef CLK_EN_GEN_PHASE_EN
    assign preload = load_phase;
`else
    logic unused_phase;
    assign unused_phase = ^load_phase;
    assign preload      = '0;
`endif

    assign sum = {1'b0, acc} + {1'b0, inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            inc    <= '0;
            strobe <= 1'b0;
            msb    <= 1'b0;
        end else if (load) begin
            acc    <= preload;
            inc    <= load_inc;
            strobe <= 1'b0;
            msb    <= preload[ACC_W-1];
        end else begin
            acc    <= sum[ACC_W-1:0];
            strobe <= sum[ACC_W];
            msb    <= sum[ACC_W-1];
        end
    end

endmodule

// File: rtl/clk_en_gen_n.sv
// clk_en_gen_n: NUM_CLK-channel fractional clock-enable generator with a
// PLL-like lock indicator.
//   refclk     - sole clock
//   rst_n      - async active-low reset
//   cfg_valid  - config request
//   cfg_ready  - config accept (low during reset and the LOAD cycle)
//   cfg_ch     - target channel (out-of-range values are accepted, ignored)
//   cfg_inc    - frequency word, f_out = f_refclk * cfg_inc / 2^ACC_W
//   cfg_phase  - accumulator preload (only with CLK_EN_GEN_PHASE_EN)
//   outclk_en  - one-cycle enable strobe per channel
//   outclk     - registered accumulator MSB per channel
//   locked     - high once SETTLE cycles elapsed since reset/last load
// Macro CLK_EN_GEN_PHASE_EN enables phase preload (see clk_en_nco).
module clk_en_gen_n
    import clk_en_gen_pkg::*;
#(
    parameter  int unsigned NUM_CLK = 2,
    parameter  int unsigned ACC_W   = 32,
    parameter  int unsigned SETTLE  = 1024,
    localparam int unsigned CH_W    = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [ACC_W-1:0]   cfg_inc,
    input  logic [ACC_W-1:0]   cfg_phase,
    output logic [NUM_CLK-1:0] outclk_en,
    output logic [NUM_CLK-1:0] outclk,
    output logic               locked
);

    localparam int unsigned     CNT_W    = settle_cnt_w(SETTLE);
    localparam logic [CNT_W-1:0] CNT_LAST = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);

    if (NUM_CLK < 1 || NUM_CLK > MAX_NUM_CLK) begin : g_bad_num_clk
        $error("clk_en_gen_n: NUM_CLK out of range");
    end
    if (ACC_W < MIN_ACC_W || ACC_W > MAX_ACC_W) begin : g_bad_acc_w
        $error("clk_en_gen_n: ACC_W out of range");
    end

    state_t             state;
    logic [CNT_W-1:0]   settle_cnt;
    logic               accept;
    logic [NUM_CLK-1:0] ch_load;

    assign accept = cfg_valid && cfg_ready;

    // The channel is written on the handshake edge itself, so its new
    // settings are live during the LOAD cycle.
    always_comb begin
        ch_load = '0;
        for (int unsigned i = 0; i < NUM_CLK; i++) begin
            ch_load[i] = accept && (cfg_ch == CH_W'(i));
        end
    end

    // locked follows the LOCKED state by one cycle; an accept drops it on
    // the handshake edge.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            locked     <= 1'b0;
            cfg_ready  <= 1'b0;
        end else begin
            case (state)
                ST_SETTLE: begin
                    locked <= 1'b0;
                    if (accept) begin
                        state      <= ST_LOAD;
                        settle_cnt <= '0;
                        cfg_ready  <= 1'b0;
                    end else if (SETTLE == 0 || settle_cnt == CNT_LAST) begin
                        state     <= ST_LOCKED;
                        cfg_ready <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                        cfg_ready  <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (accept) begin
                        state      <= ST_LOAD;
                        settle_cnt <= '0;
                        cfg_ready  <= 1'b0;
                        locked     <= 1'b0;
                    end else begin
                        cfg_ready <= 1'b1;
                        locked    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                    cfg_ready  <= 1'b1;
                    locked     <= 1'b0;
                end
                default: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                    cfg_ready  <= 1'b0;
                    locked     <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CLK; g++) begin : g_ch
        clk_en_nco #(
            .ACC_W(ACC_W)
        ) u_nco (
            .clk        (refclk),
            .rst_n      (rst_n),
            .load       (ch_load[g]),
            .load_inc   (cfg_inc),
            .load_phase (cfg_phase),
            .strobe     (outclk_en[g]),
            .msb        (outclk[g])
        );
    end

endmodule
